iterative_divider: RTL and testbench

Parametrised sequential integer divider, the successor to the fixed 32-bit divider core. It produces a quotient and a remainder through restoring radix-2 division, one quotient bit per clock. It adds signed and unsigned modes, a start/busy/valid handshake, and defined divide-by-zero and signed-overflow results. It sits beside the datapath as a multi-cycle arithmetic unit and is fed by a sequencer that issues one operation at a time.

---
 rtl/iterative_divider_if.sv | 27 ++
 rtl/iterative_divider.sv | 140 ++++++++++++++
 tb/tb_iterative_divider.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/iterative_divider_if.sv
// Request/response bundle for the iterative divider: operands and mode in,
// busy/valid handshake and results out.
interface iterative_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_start;
    logic             i_signed;
    logic [WIDTH-1:0] i_dividend;
    logic [WIDTH-1:0] i_divisor;
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_quotient;
    logic [WIDTH-1:0] o_remainder;
    logic             o_div_by_zero;

    // Sequencer side: issues requests, observes results
    modport master (
        output i_start, i_signed, i_dividend, i_divisor,
        input  o_busy, o_valid, o_quotient, o_remainder, o_div_by_zero
    );

    // Divider side
    modport slave (
        input  i_start, i_signed, i_dividend, i_divisor,
        output o_busy, o_valid, o_quotient, o_remainder, o_div_by_zero
    );
endinterface

// File: rtl/iterative_divider.sv
// Restoring radix-2 divider, one quotient bit per clock, signed/unsigned,
// with fixed divide-by-zero result and untrapped signed overflow.
module iterative_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    iterative_divider_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t           state_q,   state_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q,     dbz_d;
    logic [WIDTH-1:0] dvd_q,     dvd_d;
    logic [WIDTH-1:0] dvs_q,     dvs_d;
    logic [WIDTH:0]   rem_q,     rem_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_out_q, dbz_out_d;
    logic             valid_q,   valid_d;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    assign dvd_neg = bus.i_signed & bus.i_dividend[WIDTH-1];
    assign dvs_neg = bus.i_signed & bus.i_divisor[WIDTH-1];

    // Partial remainder always stays below the divisor, so its top bit is 0
    // and the borrow out of the extra MSB marks a negative trial result.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs_q};

    // Next-state, datapath and result registers
    always_comb begin
        state_d   = state_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_out_d = dbz_out_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    dvs_d     = dvs_neg ? -bus.i_divisor : bus.i_divisor;
                    neg_quo_d = dvd_neg ^ dvs_neg;
                    neg_rem_d = dvd_neg;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (bus.i_divisor == '0) begin
                        // Raw dividend kept so it can be returned unmodified
                        dbz_d   = 1'b1;
                        dvd_d   = bus.i_dividend;
                        state_d = FIXUP;
                    end else begin
                        dbz_d   = 1'b0;
                        dvd_d   = dvd_neg ? -bus.i_dividend : bus.i_dividend;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH:0];
                    dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                valid_d   = 1'b1;
                dbz_out_d = dbz_q;
                if (dbz_q) begin
                    quo_out_d = '1;
                    rem_out_d = dvd_q;
                end else begin
                    quo_out_d = neg_quo_q ? -dvd_q : dvd_q;
                    rem_out_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_out_q <= dbz_out_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.o_busy        = (state_q != IDLE);
    assign bus.o_valid       = valid_q;
    assign bus.o_quotient    = quo_out_q;
    assign bus.o_remainder   = rem_out_q;
    assign bus.o_div_by_zero = dbz_out_q;
endmodule

// File: tb/tb_iterative_divider.sv
// Bench for iterative_divider: 32-bit and 8-bit instances, directed cases,
// handshake/reset scenarios and randomized ops against an arithmetic model.
module tb_iterative_divider;
    logic i_clk;
    logic i_rst_n;
    int   checks;
    int   errors;

    iterative_divider_if #(.WIDTH(32)) if32 ();
    iterative_divider_if #(.WIDTH(8))  if8  ();

    iterative_divider #(.WIDTH(32)) dut32 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if32));
    iterative_divider #(.WIDTH(8))  dut8  (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(if8));

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division on sign-extended operands
    function automatic void ref_div(input int w, input logic sg, input logic [31:0] a_in,
                                    input logic [31:0] b_in, output logic [31:0] q,
                                    output logic [31:0] r, output logic z);
        longint sa, sb, sq, sr;
        logic [31:0] m, a, b;
        m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        a = a_in & m;
        b = b_in & m;
        if (b == 0) begin
            q = m; r = a; z = 1'b1;
            return;
        end
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
        if (sg && a[w-1]) sa = sa - (longint'(1) << w);
        if (sg && b[w-1]) sb = sb - (longint'(1) << w);
        sq = sa / sb;
        sr = sa % sb;
        q = sq[31:0] & m;
        r = sr[31:0] & m;
        z = 1'b0;
    endfunction

    task automatic drive(input int w, input logic s, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            if32.i_start = s; if32.i_signed = sg; if32.i_dividend = a; if32.i_divisor = b;
        end else begin
            if8.i_start = s; if8.i_signed = sg; if8.i_dividend = a[7:0]; if8.i_divisor = b[7:0];
        end
    endtask

    function automatic logic f_valid(input int w);
        return (w == 32) ? if32.o_valid : if8.o_valid;
    endfunction
    function automatic logic f_busy(input int w);
        return (w == 32) ? if32.o_busy : if8.o_busy;
    endfunction
    function automatic logic f_dbz(input int w);
        return (w == 32) ? if32.o_div_by_zero : if8.o_div_by_zero;
    endfunction
    function automatic logic [31:0] f_quo(input int w);
        return (w == 32) ? if32.o_quotient : {24'b0, if8.o_quotient};
    endfunction
    function automatic logic [31:0] f_rem(input int w);
        return (w == 32) ? if32.o_remainder : {24'b0, if8.o_remainder};
    endfunction

    // One operation; poke_at > 0 issues a competing request that cycle
    task automatic run_op(input int w, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at);
        logic [31:0] eq, er;
        logic        ez, got;
        int          k, lat;
        ref_div(w, sg, a, b, eq, er, ez);
        lat = ez ? 1 : w + 1;
        @(negedge i_clk);
        drive(w, 1'b1, sg, a, b);
        @(posedge i_clk); #1;
        check("busy_after_accept", {31'b0, f_busy(w)}, 32'd1);
        drive(w, 1'b0, ~sg, ~a, b + 32'd1);
        k = 0; got = 1'b0;
        while (!got && k < 100) begin
            @(posedge i_clk); #1;
            k++;
            if (f_valid(w)) got = 1'b1;
            else if (k == poke_at) drive(w, 1'b1, ~sg, 32'd100, 32'd7);
            else if (k == poke_at + 1) drive(w, 1'b0, sg, 32'd0, 32'd0);
        end
        check("valid_seen", {31'b0, got}, 32'd1);
        check("latency", k, lat);
        check("quotient", f_quo(w), eq);
        check("remainder", f_rem(w), er);
        check("div_by_zero", {31'b0, f_dbz(w)}, {31'b0, ez});
        check("busy_at_valid", {31'b0, f_busy(w)}, 32'd0);
        @(posedge i_clk); #1;
        check("valid_one_cycle", {31'b0, f_valid(w)}, 32'd0);
    endtask

    task automatic watch_no_valid(input int w, input int cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge i_clk); #1;
            if (f_valid(w)) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        i_rst_n = 1'b0;
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", {30'b0, if32.o_busy, if8.o_busy}, 32'd0);
        check("rst_valid", {30'b0, if32.o_valid, if8.o_valid}, 32'd0);
        check("rst_quo", if32.o_quotient, 32'd0);
        check("rst_rem", if32.o_remainder, 32'd0);
        check("rst_dbz", {31'b0, if32.o_div_by_zero}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Directed cases
        run_op(32, 1'b0, 32'd5421, 32'd3, -1);
        run_op(32, 1'b0, 32'd113, 32'd2, -1);
        run_op(32, 1'b1, -32'sd7, 32'd2, -1);
        run_op(32, 1'b1, 32'd7, -32'sd2, -1);
        run_op(32, 1'b1, -32'sd7, -32'sd2, -1);
        run_op(32, 1'b0, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(32, 1'b0, 32'd100, 32'd0, -1);
        run_op(32, 1'b1, 32'd100, 32'd0, -1);
        run_op(32, 1'b1, -32'sd100, 32'd0, -1);
        run_op(32, 1'b0, 32'd9, 32'd4, -1);
        run_op(8, 1'b1, 32'h80, 32'hFF, -1);
        run_op(8, 1'b0, 32'd255, 32'd1, -1);
        run_op(8, 1'b1, 32'h81, 32'd0, -1);

        // Competing request mid-CALC: ignored and not queued
        run_op(32, 1'b0, 32'd5421, 32'd3, 5);
        watch_no_valid(32, 40, "no_queued_op");

        // Held start on the 8-bit instance: 200/7 every WIDTH+2 clocks
        begin
            int   last, nres;
            logic prev;
            last = -1; nres = 0; prev = 1'b0;
            @(negedge i_clk);
            drive(8, 1'b1, 1'b0, 32'd200, 32'd7);
            for (int cyc = 0; cyc < 36; cyc++) begin
                @(posedge i_clk); #1;
                if (if8.o_valid) begin
                    if (last >= 0) check("held_period", cyc - last, 32'd10);
                    check("held_quo", {24'b0, if8.o_quotient}, 32'd28);
                    check("held_rem", {24'b0, if8.o_remainder}, 32'd4);
                    check("held_no_double", {31'b0, prev}, 32'd0);
                    last = cyc;
                    nres++;
                end
                prev = if8.o_valid;
            end
            check("held_results", nres, 32'd3);
            drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
            for (int i = 0; i < 30 && if8.o_busy; i++) begin
                @(posedge i_clk); #1;
            end
            check("held_drain", {31'b0, if8.o_busy}, 32'd0);
        end

        // Reset at iteration 10 discards the operation
        @(negedge i_clk);
        drive(32, 1'b1, 1'b0, 32'd5421, 32'd3);
        @(posedge i_clk); #1;
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (10) @(posedge i_clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, if32.o_busy}, 32'd0);
        check("mid_rst_valid", {31'b0, if32.o_valid}, 32'd0);
        check("mid_rst_quo", if32.o_quotient, 32'd0);
        check("mid_rst_rem", if32.o_remainder, 32'd0);
        check("mid_rst_dbz", {31'b0, if32.o_div_by_zero}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        watch_no_valid(32, 40, "no_valid_after_rst");
        run_op(32, 1'b0, 32'd5421, 32'd3, -1);

        // Randomized operations on both widths
        for (int n = 0; n < 60; n++) begin
            int          w;
            logic        sg;
            logic [31:0] a, b;
            w  = (n % 2 == 0) ? 32 : 8;
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if (w == 8 && b[7:0] == 8'd0 && $urandom_range(0, 1) == 1) b = 32'd3;
            run_op(w, sg, a, b, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
